// File: rtl/bip_pkg.sv
// Shared BIP definitions: opcode map used by the decoder and the run-controller state encoding.
package bip_pkg;

  localparam logic [4:0] HLT  = 5'd0;
  localparam logic [4:0] STO  = 5'd1;
  localparam logic [4:0] LD   = 5'd2;
  localparam logic [4:0] LDI  = 5'd3;
  localparam logic [4:0] ADD  = 5'd4;
  localparam logic [4:0] ADDI = 5'd5;
  localparam logic [4:0] SUB  = 5'd6;
  localparam logic [4:0] SUBI = 5'd7;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StReport,
    StDone
  } run_state_e;

  function automatic logic is_busy(run_state_e s);
    return s inside {StClear, StRun, StReport};
  endfunction

endpackage

// File: rtl/bip_run_controller_if.sv
// Valid/ready byte stream carrying the instruction-count report toward the UART transmitter.
interface bip_run_controller_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/bip_count_serializer.sv
// Sends a CNT_WIDTH-bit count as CNT_WIDTH/8 bytes, LS byte first, over a valid/ready stream.
module bip_count_serializer #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_count,
  output logic                 o_done,
  bip_run_controller_if.master tx
);

  localparam int unsigned NBytes = CNT_WIDTH / 8;
  localparam int unsigned IdxW   = (NBytes > 1) ? $clog2(NBytes) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBytes - 1);

  logic [CNT_WIDTH-1:0] r_shift;
  logic [IdxW-1:0]      r_idx;
  logic [7:0]           r_data;
  logic                 r_valid;
  logic                 w_hs;
  logic                 w_last;

  assign w_hs   = r_valid & tx.tx_ready;
  assign w_last = (r_idx == LastIdx);
  assign o_done = w_hs & w_last;

  assign tx.tx_data  = r_data;
  assign tx.tx_valid = r_valid;

  // r_shift holds the bytes not yet presented; r_data is the byte on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_count >> 8;
      r_data  <= i_count[7:0];
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (w_hs) begin
      if (w_last) begin
        r_data  <= '0;
        r_idx   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_data  <= r_shift[7:0];
        r_shift <= r_shift >> 8;
        r_idx   <= r_idx + IdxW'(1);
      end
    end
  end

endmodule

// File: rtl/bip_run_controller.sv
// BIP run controller: sequences a run, gates decoder enables, reports the instruction count.
// Optional single-step execution is built only when RUN_STEP_EN is defined.
module bip_run_controller
  import bip_pkg::*;
#(
  parameter int unsigned              OPCODE_LENGTH = 5,
  parameter int unsigned              CNT_WIDTH     = 16,
  parameter logic [OPCODE_LENGTH-1:0] HLT_CODE      = OPCODE_LENGTH'(HLT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic                     i_step_mode,
  input  logic                     i_step,
  input  logic [OPCODE_LENGTH-1:0] i_opcode,
  input  logic                     i_dec_wr_pc,
  input  logic                     i_dec_wr_acc,
  input  logic                     i_dec_wr_ram,
  input  logic                     i_dec_rd_ram,
  output logic                     o_wr_pc,
  output logic                     o_wr_acc,
  output logic                     o_wr_ram,
  output logic                     o_rd_ram,
  output logic                     o_cpu_clr,
  output logic                     o_busy,
  output logic                     o_halted,
  bip_run_controller_if.master     tx
);

  run_state_e           r_state;
  run_state_e           w_state_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 r_cpu_clr;
  logic                 r_busy;
  logic                 r_halted;
  logic                 w_exec;
  logic                 w_hlt;
  logic                 w_gate;
  logic                 w_ser_done;

`ifdef RUN_STEP_EN
  assign w_exec = (r_state == StRun) && (!i_step_mode || i_step);
`else
  logic w_unused_step;
  assign w_unused_step = i_step_mode ^ i_step;
  assign w_exec        = (r_state == StRun);
`endif

  assign w_hlt  = w_exec && (i_opcode == HLT_CODE);
  assign w_gate = w_exec && !w_hlt;

  assign o_wr_pc   = w_gate & i_dec_wr_pc;
  assign o_wr_acc  = w_gate & i_dec_wr_acc;
  assign o_wr_ram  = w_gate & i_dec_wr_ram;
  assign o_rd_ram  = w_gate & i_dec_rd_ram;
  assign o_cpu_clr = r_cpu_clr;
  assign o_busy    = r_busy;
  assign o_halted  = r_halted;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (i_start) w_state_next = StClear;
      StClear:  w_state_next = StRun;
      StRun:    if (w_hlt) w_state_next = StReport;
      StReport: if (w_ser_done) w_state_next = StDone;
      StDone:   if (i_start) w_state_next = StClear;
      default:  w_state_next = StIdle;
    endcase
  end

  // Saturating count; the HLT cycle is counted too.
  always_comb begin
    w_cnt_next = r_cnt;
    if (r_state == StClear) begin
      w_cnt_next = '0;
    end else if (w_exec && (r_cnt != '1)) begin
      w_cnt_next = r_cnt + CNT_WIDTH'(1);
    end
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_cpu_clr <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_cpu_clr <= (w_state_next == StClear);
      r_busy    <= is_busy(w_state_next);
      r_halted  <= (w_state_next == StDone);
    end
  end

  bip_count_serializer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_serializer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_hlt),
    .i_count (w_cnt_next),
    .o_done  (w_ser_done),
    .tx      (tx)
  );

endmodule

// File: tb/tb_bip_run_controller.sv
// Bench for bip_run_controller: directed programs, random runs and a CNT_WIDTH=8 saturation check.
module tb_bip_run_controller;
  import bip_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, step_mode, step;
  logic [4:0] opcode;
  logic       dwp, dwa, dwr, drr;
  logic       wr_pc, wr_acc, wr_ram, rd_ram, cpu_clr, busy, halted;
  logic [3:0] gated, dec;

  logic       start8;
  logic [4:0] op8;
  logic       wp8, wa8, wr8, rr8, clr8, busy8, halt8;
  logic [3:0] gated8;

  int checks   = 0;
  int failures = 0;
  int exp_cnt;
  logic [4:0] prog[$];

  always #5 clk = ~clk;

  assign gated  = {wr_pc, wr_acc, wr_ram, rd_ram};
  assign gated8 = {wp8, wa8, wr8, rr8};
  assign dec    = {dwp, dwa, dwr, drr};

  bip_run_controller_if tx_if ();
  bip_run_controller_if tx8_if ();

  bip_run_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_step_mode  (step_mode),
    .i_step       (step),
    .i_opcode     (opcode),
    .i_dec_wr_pc  (dwp),
    .i_dec_wr_acc (dwa),
    .i_dec_wr_ram (dwr),
    .i_dec_rd_ram (drr),
    .o_wr_pc      (wr_pc),
    .o_wr_acc     (wr_acc),
    .o_wr_ram     (wr_ram),
    .o_rd_ram     (rd_ram),
    .o_cpu_clr    (cpu_clr),
    .o_busy       (busy),
    .o_halted     (halted),
    .tx           (tx_if)
  );

  bip_run_controller #(
    .CNT_WIDTH (8)
  ) dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start8),
    .i_step_mode  (1'b0),
    .i_step       (1'b0),
    .i_opcode     (op8),
    .i_dec_wr_pc  (dwp),
    .i_dec_wr_acc (dwa),
    .i_dec_wr_ram (dwr),
    .i_dec_rd_ram (drr),
    .o_wr_pc      (wp8),
    .o_wr_acc     (wa8),
    .o_wr_ram     (wr8),
    .o_rd_ram     (rr8),
    .o_cpu_clr    (clr8),
    .o_busy       (busy8),
    .o_halted     (halt8),
    .tx           (tx8_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_dec();
    {dwp, dwa, dwr, drr} = 4'($urandom);
  endtask

  // Issue start from IDLE/DONE, then check the single CLEAR cycle.
  task automatic do_start();
    start  = 1'b1;
    opcode = 5'($urandom_range(1, 7));
    rand_dec();
    #1;
    chk("pre_start_gate", 32'(gated), 32'h0);
    tick();
    start = 1'b0;
    rand_dec();
    #1;
    chk("clear_cpu_clr", 32'(cpu_clr), 32'h1);
    chk("clear_busy", 32'(busy), 32'h1);
    chk("clear_halted", 32'(halted), 32'h0);
    chk("clear_gate", 32'(gated), 32'h0);
  endtask

  // Execute prog until HLT; exp_cnt = instructions executed including HLT.
  task automatic do_run(input bit sm, input int idle_cycles, input bit rand_start);
    int  pc = 0;
    int  cyc = 0;
    bit  done = 1'b0;
    bit  exec, hlt;
    exp_cnt = 0;
    tick();
    while (!done && cyc < 3000) begin
      opcode    = prog[pc];
      step_mode = sm;
      step      = (cyc >= idle_cycles) && ($urandom_range(0, 1) == 1);
      start     = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
      rand_dec();
      #1;
`ifdef RUN_STEP_EN
      exec = !step_mode || step;
`else
      exec = 1'b1;
`endif
      hlt = exec && (opcode == HLT);
      chk("run_gate", 32'(gated), (exec && !hlt) ? 32'(dec) : 32'h0);
      chk("run_busy", 32'(busy), 32'h1);
      chk("run_cpu_clr", 32'(cpu_clr), 32'h0);
      chk("run_tx_valid", 32'(tx_if.tx_valid), 32'h0);
      tick();
      if (exec) begin
        pc++;
        exp_cnt++;
        if (hlt) done = 1'b1;
      end
      cyc++;
    end
    step_mode = 1'b0;
    step      = 1'b0;
    start     = 1'b0;
    if (!done) chk("run_timeout", 32'h0, 32'h1);
  endtask

  // ready_mode 0: always ready; 1: ready low 4 cycles on byte 0; 2: random.
  task automatic do_report(input int ready_mode, input int stop_after);
    int sent = 0;
    int wait_cyc = 0;
    int cyc = 0;
    logic [7:0] exp_byte;
    while (sent < stop_after && cyc < 500) begin
      exp_byte = 8'(exp_cnt >> (8 * sent));
      case (ready_mode)
        0:       tx_if.tx_ready = 1'b1;
        1:       tx_if.tx_ready = (sent != 0) || (wait_cyc >= 4);
        default: tx_if.tx_ready = 1'($urandom_range(0, 1));
      endcase
      start = 1'($urandom_range(0, 1));
      rand_dec();
      #1;
      chk("rep_valid", 32'(tx_if.tx_valid), 32'h1);
      chk("rep_data", 32'(tx_if.tx_data), 32'(exp_byte));
      chk("rep_busy", 32'(busy), 32'h1);
      chk("rep_halted", 32'(halted), 32'h0);
      chk("rep_gate", 32'(gated), 32'h0);
      tick();
      if (tx_if.tx_ready) begin
        sent++;
        wait_cyc = 0;
      end else begin
        wait_cyc++;
      end
      cyc++;
    end
    start          = 1'b0;
    tx_if.tx_ready = 1'b0;
    if (sent < stop_after) chk("rep_timeout", 32'h0, 32'h1);
    if (stop_after == 2) begin
      chk("done_halted", 32'(halted), 32'h1);
      chk("done_busy", 32'(busy), 32'h0);
      chk("done_valid", 32'(tx_if.tx_valid), 32'h0);
    end
  endtask

  task automatic run8(input int n_addi);
    int exp8;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("sat_clear", 32'(clr8), 32'h1);
    tick();
    for (int c = 0; c <= n_addi; c++) begin
      op8 = (c < n_addi) ? ADDI : HLT;
      rand_dec();
      #1;
      chk("sat_gate", 32'(gated8), (c < n_addi) ? 32'(dec) : 32'h0);
      tick();
    end
    exp8 = (n_addi + 1 > 255) ? 255 : n_addi + 1;
    chk("sat_valid", 32'(tx8_if.tx_valid), 32'h1);
    chk("sat_byte", 32'(tx8_if.tx_data), 32'(exp8));
    tx8_if.tx_ready = 1'b1;
    tick();
    tx8_if.tx_ready = 1'b0;
    chk("sat_halted", 32'(halt8), 32'h1);
    chk("sat_valid_off", 32'(tx8_if.tx_valid), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; step_mode = 1'b0; step = 1'b0; opcode = HLT;
    {dwp, dwa, dwr, drr} = 4'hF;
    start8 = 1'b0; op8 = ADDI;
    tx_if.tx_ready = 1'b0; tx8_if.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_cpu_clr", 32'(cpu_clr), 32'h0);
    chk("rst_valid", 32'(tx_if.tx_valid), 32'h0);
    chk("rst_data", 32'(tx_if.tx_data), 32'h0);
    chk("rst_gate", 32'(gated), 32'h0);
    rst_n = 1'b1;
    tick();
    #1;
    chk("idle_gate", 32'(gated), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    // LDI 5, ADDI 3, HLT with tx_ready held high, then with a stalled first byte.
    prog = '{LDI, ADDI, HLT};
    do_start();
    do_run(1'b0, 0, 1'b0);
    do_report(0, 2);
    do_start();
    do_run(1'b0, 0, 1'b1);
    do_report(1, 2);

    // Step mode: ten idle cycles, then random step pulses.
    do_start();
    do_run(1'b1, 10, 1'b0);
    do_report(0, 2);

    // Reset after byte 0 of the report; the rerun must report from the first byte.
    do_start();
    do_run(1'b0, 0, 1'b0);
    do_report(0, 1);
    rst_n = 1'b0;
    {dwp, dwa, dwr, drr} = 4'hF;
    #1;
    chk("midrst_valid", 32'(tx_if.tx_valid), 32'h0);
    chk("midrst_data", 32'(tx_if.tx_data), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_halted", 32'(halted), 32'h0);
    chk("midrst_gate", 32'(gated), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    do_start();
    do_run(1'b0, 0, 1'b0);
    do_report(0, 2);

    // Random programs, random ready, start noise during RUN and REPORT.
    for (int r = 0; r < 6; r++) begin
      int n = (r == 0) ? 300 : int'($urandom_range(0, 40));
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(5'($urandom_range(1, 7)));
      prog.push_back(HLT);
      do_start();
      do_run(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b1);
      do_report(2, 2);
    end

    // 8-bit counter boundaries: exactly full, and past full.
    run8(254);
    run8(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
